// File: rtl/result_serializer_if.sv
// result_serializer_if: load/transmit handshake and serial output bundle between the flow controller and the serializer.
interface result_serializer_if #(
   parameter int DATA_W = 8,
   parameter int FLAG_W = 4
);
   logic              p_load;
   logic              tx_dat;
   logic [DATA_W-1:0] data_in;
   logic [FLAG_W-1:0] flags_in;
   logic              sout;
   logic              out_valid;
   logic              tx_busy;
   logic              tx_done;
   modport master(output p_load, tx_dat, data_in, flags_in, input sout, out_valid, tx_busy, tx_done);
   modport slave(input p_load, tx_dat, data_in, flags_in, output sout, out_valid, tx_busy, tx_done);
endinterface

// File: rtl/result_serializer.sv
// result_serializer: captures {flags,data} and shifts it out MSB-first with an optional trailing even-parity bit.
module result_serializer #(
   parameter int DATA_W    = 8,
   parameter int FLAG_W    = 4,
   parameter int PARITY_EN = 1
) (
   input logic          clk,
   input logic          reset,
   result_serializer_if.slave bus
);
   localparam int FRAME_W = FLAG_W + DATA_W;
   localparam int NBITS   = FRAME_W + ((PARITY_EN != 0) ? 1 : 0);
   localparam int CW      = $clog2(NBITS + 1);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] HOLD = 2'd1;
   localparam logic [1:0] SEND = 2'd2;
   localparam logic [1:0] DONE = 2'd3;
   logic [1:0]         state;
   logic [FRAME_W-1:0] frame;
   logic [FRAME_W-1:0] cap;
   logic               par;
   logic [CW-1:0]      cnt;
   logic               send_par;
   assign cap = {bus.flags_in, bus.data_in};
   // the final shift slot carries the parity latched at capture instead of a frame bit
   assign send_par = (PARITY_EN != 0) && (cnt == CW'(1));
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         frame         <= '0;
         par           <= 1'b0;
         cnt           <= '0;
         bus.sout      <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.tx_busy   <= 1'b0;
         bus.tx_done   <= 1'b0;
      end else begin
         case (state)
            IDLE, HOLD: begin
               if (bus.p_load) begin
                  frame <= cap;
                  par   <= ^cap;
               end
               if (bus.tx_dat && (bus.p_load || state == HOLD)) begin
                  state         <= SEND;
                  bus.sout      <= bus.p_load ? cap[FRAME_W-1] : frame[FRAME_W-1];
                  bus.out_valid <= 1'b1;
                  bus.tx_busy   <= 1'b1;
                  cnt           <= CW'(NBITS - 1);
               end else if (bus.p_load) begin
                  state <= HOLD;
               end
            end
            SEND: begin
               if (cnt != '0) begin
                  frame    <= frame << 1;
                  bus.sout <= send_par ? par : frame[FRAME_W-2];
                  cnt      <= cnt - 1'b1;
               end else begin
                  state         <= DONE;
                  bus.sout      <= 1'b0;
                  bus.out_valid <= 1'b0;
                  bus.tx_done   <= 1'b1;
               end
            end
            DONE: begin
               state       <= IDLE;
               bus.tx_done <= 1'b0;
               bus.tx_busy <= 1'b0;
               frame       <= '0;
               par         <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_result_serializer.sv
// tb_result_serializer: scoreboard bench for the parity and no-parity serializer variants.
module tb_result_serializer;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;
   result_serializer_if #(.DATA_W(8), .FLAG_W(4)) ia ();
   result_serializer_if #(.DATA_W(8), .FLAG_W(4)) ib ();
   result_serializer #(.DATA_W(8), .FLAG_W(4), .PARITY_EN(1)) dut_a (.clk(clk), .reset(reset), .bus(ia));
   result_serializer #(.DATA_W(8), .FLAG_W(4), .PARITY_EN(0)) dut_b (.clk(clk), .reset(reset), .bus(ib));
   typedef struct {
      logic [7:0] d;
      logic [3:0] f;
      logic       p;
      logic       s;
   } vec_t;
   vec_t tv[8];
   int   n_cmp = 0;
   int   n_err = 0;
   logic qa[$];
   logic qb[$];
   int   vcnt_a = 0, vcnt_b = 0, done_a = 0, done_b = 0;
   logic pd_a = 1'b0, pd_b = 1'b0;
   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic flag_err(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: got event expected none", name);
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   // monitors sample mid-cycle, well away from the rising edge
   always @(negedge clk) begin
      if (!reset) begin
         if (ia.out_valid) begin
            vcnt_a++;
            check("a_busy_with_valid", int'(ia.tx_busy), 1);
            if (qa.size() == 0) flag_err("a_unexpected_bit");
            else check("a_sout", int'(ia.sout), int'(qa.pop_front()));
         end
         if (ia.tx_done) begin
            done_a++;
            check("a_done_repeat", int'(pd_a), 0);
            check("a_busy_in_done", int'(ia.tx_busy), 1);
         end
         pd_a = ia.tx_done;
         if (ib.out_valid) begin
            vcnt_b++;
            if (qb.size() == 0) flag_err("b_unexpected_bit");
            else check("b_sout", int'(ib.sout), int'(qb.pop_front()));
         end
         if (ib.tx_done) begin
            done_b++;
            check("b_done_repeat", int'(pd_b), 0);
         end
         pd_b = ib.tx_done;
      end
   end
   task automatic push_frame(input logic [7:0] d, input logic [3:0] f, input logic p, input bit to_b);
      logic [11:0] fr;
      fr = {f, d};
      for (int i = 11; i >= 0; i--) begin
         if (to_b) qb.push_back(fr[i]);
         else qa.push_back(fr[i]);
      end
      if (!to_b) qa.push_back(p);
   endtask
   task automatic start_a(input logic [7:0] d, input logic [3:0] f, input logic p, input logic s,
                          output int v0, output int d0);
      v0 = vcnt_a;
      d0 = done_a;
      ia.data_in  = d;
      ia.flags_in = f;
      ia.p_load   = 1'b1;
      ia.tx_dat   = s;
      if (!s) begin
         tick();
         ia.p_load = 1'b0;
         check("hold_valid", int'(ia.out_valid), 0);
         check("hold_busy", int'(ia.tx_busy), 0);
         ia.tx_dat = 1'b1;
      end
      push_frame(d, f, p, 1'b0);
      tick();
      ia.p_load = 1'b0;
      ia.tx_dat = 1'b0;
      check("first_bit_valid", int'(ia.out_valid), 1);
   endtask
   task automatic wait_a(input int v0, input int d0, input string tag);
      int k;
      for (k = 0; k < 60; k++) begin
         tick();
         if (done_a != d0) break;
      end
      if (k == 60) flag_err({tag, "_timeout"});
      tick();
      check({tag, "_done_count"}, done_a - d0, 1);
      check({tag, "_valid_len"}, vcnt_a - v0, 13);
      check({tag, "_queue_left"}, qa.size(), 0);
      check({tag, "_idle_busy"}, int'(ia.tx_busy), 0);
   endtask
   initial begin
      int v0, d0, k;
      tv[0] = '{8'hA5, 4'h3, 1'b0, 1'b0};
      tv[1] = '{8'hFF, 4'h1, 1'b1, 1'b1};
      tv[2] = '{8'h00, 4'h0, 1'b0, 1'b0};
      tv[3] = '{8'hFF, 4'hF, 1'b0, 1'b1};
      tv[4] = '{8'h80, 4'h0, 1'b1, 1'b0};
      tv[5] = '{8'h3C, 4'hA, 1'b0, 1'b1};
      tv[6] = '{8'h7E, 4'h7, 1'b1, 1'b0};
      tv[7] = '{8'h01, 4'h8, 1'b0, 1'b1};
      reset = 1'b1;
      ia.p_load = 0; ia.tx_dat = 0; ia.data_in = 0; ia.flags_in = 0;
      ib.p_load = 0; ib.tx_dat = 0; ib.data_in = 0; ib.flags_in = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check("rst_sout", int'(ia.sout), 0);
      check("rst_valid", int'(ia.out_valid), 0);
      check("rst_busy", int'(ia.tx_busy), 0);
      check("rst_done", int'(ia.tx_done), 0);
      check("rst_b_valid", int'(ib.out_valid), 0);
      check("rst_b_busy", int'(ib.tx_busy), 0);
      ia.tx_dat = 1'b1;
      tick();
      ia.tx_dat = 1'b0;
      check("txdat_alone_valid", int'(ia.out_valid), 0);
      check("txdat_alone_busy", int'(ia.tx_busy), 0);
      tick();
      check("txdat_alone_valid2", int'(ia.out_valid), 0);
      for (int i = 0; i < 8; i++) begin
         start_a(tv[i].d, tv[i].f, tv[i].p, tv[i].s, v0, d0);
         wait_a(v0, d0, $sformatf("vec%0d", i));
      end
      // reload in HOLD: only the second word may go out
      v0 = vcnt_a; d0 = done_a;
      ia.data_in = 8'h0F; ia.flags_in = 4'h0; ia.p_load = 1'b1;
      tick();
      check("reload_busy", int'(ia.tx_busy), 0);
      ia.data_in = 8'hF0;
      tick();
      ia.p_load = 1'b0;
      check("reload_valid", int'(ia.out_valid), 0);
      ia.tx_dat = 1'b1;
      push_frame(8'hF0, 4'h0, 1'b0, 1'b0);
      tick();
      ia.tx_dat = 1'b0;
      wait_a(v0, d0, "reload");
      start_a(8'hA5, 4'h3, 1'b0, 1'b1, v0, d0);
      repeat (3) tick();
      ia.data_in = 8'h55; ia.flags_in = 4'h0; ia.p_load = 1'b1; ia.tx_dat = 1'b1;
      tick();
      ia.p_load = 1'b0; ia.tx_dat = 1'b0;
      check("midsend_busy", int'(ia.tx_busy), 1);
      wait_a(v0, d0, "midsend");
      start_a(8'h96, 4'h5, 1'b0, 1'b1, v0, d0);
      repeat (4) tick();
      reset = 1'b1;
      #1;
      check("abort_sout", int'(ia.sout), 0);
      check("abort_valid", int'(ia.out_valid), 0);
      check("abort_busy", int'(ia.tx_busy), 0);
      check("abort_done", int'(ia.tx_done), 0);
      qa.delete();
      d0 = done_a;
      repeat (2) tick();
      reset = 1'b0;
      repeat (20) tick();
      check("abort_no_done", done_a, d0);
      start_a(8'hA5, 4'h3, 1'b0, 1'b0, v0, d0);
      wait_a(v0, d0, "after_abort");
      v0 = vcnt_b; d0 = done_b;
      ib.data_in = 8'hA5; ib.flags_in = 4'h3; ib.p_load = 1'b1;
      tick();
      ib.p_load = 1'b0; ib.tx_dat = 1'b1;
      push_frame(8'hA5, 4'h3, 1'b0, 1'b1);
      tick();
      ib.tx_dat = 1'b0;
      for (k = 0; k < 60; k++) begin
         tick();
         if (done_b != d0) break;
      end
      if (k == 60) flag_err("nopar_timeout");
      tick();
      check("nopar_done_count", done_b - d0, 1);
      check("nopar_valid_len", vcnt_b - v0, 12);
      check("nopar_queue_left", qb.size(), 0);
      check("nopar_idle_busy", int'(ib.tx_busy), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
